alu_share_arbiter: RTL and testbench

Shares one ALU instance between NUM_REQ requesters, e.g. execute-stage ALU ops and a branch-target/address adder path. Each requester has a valid/ready request channel and a valid/ready response channel. Internally it instantiates ALU (ports A, B, sel, result, widths REG_SIZE/ALU_SEL_LEN from package risc_v_32i). A round-robin FSM sequences the shared ALU: one operation in flight at a time.

---
 rtl/alu_share_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between NUM_REQ requesters.
//
// Contents (in order):
//   risc_v_32i        - package: datapath widths and ALU op codes
//   ALU               - combinational ALU (A, B, sel -> result)
//   alu_share_arbiter - round-robin IDLE/EXEC/RESP sequencer around one ALU
//
// alu_share_arbiter ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   req_valid     per-requester request valid
//   req_ready     per-requester request accepted this cycle (IDLE only)
//   req_a, req_b  packed operands, slice i belongs to requester i
//   req_sel       packed ALU op codes, slice i belongs to requester i
//   rsp_valid     one-hot (or zero) result valid
//   rsp_ready     per-requester result consume
//   rsp_result    result for the requester flagged in rsp_valid
//   busy          high whenever the sequencer is not IDLE
//   grant_id      requester owning the ALU; valid while busy

package risc_v_32i;
    localparam int REG_SIZE    = 32;
    localparam int ALU_SEL_LEN = 4;
    localparam int SHAMT_W     = $clog2(REG_SIZE);

    localparam logic [ALU_SEL_LEN-1:0] OP_ADD = 4'd0;
    localparam logic [ALU_SEL_LEN-1:0] OP_SUB = 4'd1;
    localparam logic [ALU_SEL_LEN-1:0] OP_AND = 4'd2;
    localparam logic [ALU_SEL_LEN-1:0] OP_OR  = 4'd3;
    localparam logic [ALU_SEL_LEN-1:0] OP_XOR = 4'd4;
    localparam logic [ALU_SEL_LEN-1:0] OP_LSL = 4'd5;
    localparam logic [ALU_SEL_LEN-1:0] OP_LSR = 4'd6;
endpackage

// Combinational ALU. Shift amount is the low SHAMT_W bits of B;
// unlisted op codes produce zero.
module ALU
    import risc_v_32i::*;
(
    input  logic [REG_SIZE-1:0]    A,
    input  logic [REG_SIZE-1:0]    B,
    input  logic [ALU_SEL_LEN-1:0] sel,
    output logic [REG_SIZE-1:0]    result
);
    always_comb begin
        result = '0;
        case (sel)
            OP_ADD:  result = A + B;
            OP_SUB:  result = A - B;
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            OP_LSL:  result = A << B[SHAMT_W-1:0];
            OP_LSR:  result = A >> B[SHAMT_W-1:0];
            default: result = '0;
        endcase
    end
endmodule

module alu_share_arbiter
    import risc_v_32i::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*REG_SIZE-1:0]    req_a,
    input  logic [NUM_REQ*REG_SIZE-1:0]    req_b,
    input  logic [NUM_REQ*ALU_SEL_LEN-1:0] req_sel,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [REG_SIZE-1:0]            rsp_result,
    output logic                           busy,
    output logic [ID_W-1:0]                grant_id
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        rr_ptr;
    logic [REG_SIZE-1:0]    op_a, op_b, alu_result;
    logic [ALU_SEL_LEN-1:0] op_sel;

    logic                   found;
    logic [ID_W-1:0]        winner;
    logic [ID_W:0]          rot_sum;
    logic [ID_W-1:0]        rot_idx;
    logic [REG_SIZE-1:0]    win_a, win_b;
    logic [ALU_SEL_LEN-1:0] win_sel;
    logic                   rsp_hs;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
    // (NUM_REQ need not be a power of two, so wrap explicitly).
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        rot_sum = '0;
        rot_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rot_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (rot_sum >= (ID_W+1)'(NUM_REQ))
                rot_sum = rot_sum - (ID_W+1)'(NUM_REQ);
            rot_idx = rot_sum[ID_W-1:0];
            if (!found && req_valid[rot_idx]) begin
                found  = 1'b1;
                winner = rot_idx;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        win_a   = '0;
        win_b   = '0;
        win_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_a   = req_a[i*REG_SIZE +: REG_SIZE];
                win_b   = req_b[i*REG_SIZE +: REG_SIZE];
                win_sel = req_sel[i*ALU_SEL_LEN +: ALU_SEL_LEN];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == IDLE) && found && (winner == ID_W'(i));
            rsp_valid[i] = (state == RESP) && (grant_id == ID_W'(i));
        end
    end

    // Only the granted requester's rsp_ready matters.
    assign rsp_hs = (state == RESP) && rsp_ready[grant_id];
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            rsp_result <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                op_a     <= win_a;
                op_b     <= win_b;
                op_sel   <= win_sel;
                grant_id <= winner;
            end
            if (state == EXEC)
                rsp_result <= alu_result;
            // Pointer moves only on a completed response, so a requester
            // that keeps valid high cannot win twice in a row over others.
            if (rsp_hs)
                rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        end
    end

    // ALU sees only the latched operands, never the live request ports.
    ALU u_alu (
        .A      (op_a),
        .B      (op_b),
        .sel    (op_sel),
        .result (alu_result)
    );
endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    localparam int N  = 2;
    localparam int RS = 32;
    localparam int SL = 4;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3,
                           XOR_ = 4'd4, LSL = 4'd5, LSR = 4'd6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*RS-1:0] req_a = '0;
    logic [N*RS-1:0] req_b = '0;
    logic [N*SL-1:0] req_sel = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [RS-1:0]   rsp_result;
    logic            busy;
    logic            grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int id, input logic [3:0] sel,
                           input logic [31:0] a, input logic [31:0] b);
        req_a[id*RS +: RS]   = a;
        req_b[id*RS +: RS]   = b;
        req_sel[id*SL +: SL] = sel;
        req_valid[id]        = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        step();
        rst = 1'b0;
        step();
    endtask

    // Single request from requester id; checks accept, latency, result, release.
    task automatic run_op(input string name, input int id, input logic [3:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int n;
        logic [N-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        set_req(id, sel, a, b);
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            step();
            n++;
        end
        check({name, " accept"}, 32'(req_ready), 32'(oh));
        step();
        req_valid[id] = 1'b0;
        check({name, " exec busy"}, 32'(busy), 32'd1);
        check({name, " exec grant"}, 32'(grant_id), 32'(id));
        check({name, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
        step();
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'(oh));
        check({name, " result"}, rsp_result, exp);
        rsp_ready[id] = 1'b1;
        step();
        rsp_ready[id] = 1'b0;
        #1;
        check({name, " done rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, " done busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        string       name;
        int          id;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int grants[6];
        int times[6];
        int nacc, cyc;

        vecs[0]  = '{"add10_17",  0, ADD,  32'd10,         32'd17, 32'd27};
        vecs[1]  = '{"sub25_7",   1, SUB,  32'd25,         32'd7,  32'd18};
        vecs[2]  = '{"xor",       0, XOR_, 32'hC,          32'hA,  32'h6};
        vecs[3]  = '{"and",       1, AND_, 32'hC,          32'hA,  32'h8};
        vecs[4]  = '{"or",        0, OR_,  32'hC,          32'hA,  32'hE};
        vecs[5]  = '{"lsl1_2",    1, LSL,  32'd1,          32'd2,  32'd4};
        vecs[6]  = '{"lsr4_2",    0, LSR,  32'd4,          32'd2,  32'd1};
        vecs[7]  = '{"sub_wrap",  1, SUB,  32'd0,          32'd1,  32'hFFFF_FFFF};
        vecs[8]  = '{"add_wrap",  0, ADD,  32'hFFFF_FFFF,  32'd1,  32'd0};
        vecs[9]  = '{"lsl31",     1, LSL,  32'd1,          32'd31, 32'h8000_0000};
        vecs[10] = '{"lsl_b33",   0, LSL,  32'd1,          32'd33, 32'd2};
        vecs[11] = '{"bad_op",    1, 4'hF, 32'h1234,       32'h5,  32'd0};

        // Reset state
        #2;
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_result", rsp_result, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst grant_id", 32'(grant_id), 32'd0);
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].name, vecs[i].id, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Both valid after reset: req0 first, then req1, then req0 favoured again
        do_reset();
        set_req(0, SUB, 32'd25, 32'd7);
        set_req(1, XOR_, 32'hC, 32'hA);
        #1;
        check("both ready0", 32'(req_ready), 32'b01);
        step();
        req_valid[0] = 1'b0;
        step();
        check("both rsp0 valid", 32'(rsp_valid), 32'b01);
        check("both rsp0 result", rsp_result, 32'd18);
        rsp_ready = 2'b11;
        step();
        #1;
        check("both ready1", 32'(req_ready), 32'b10);
        step();
        req_valid[1] = 1'b0;
        step();
        check("both rsp1 valid", 32'(rsp_valid), 32'b10);
        check("both rsp1 result", rsp_result, 32'h6);
        step();

        // Continuous requests from both with rsp_ready tied high
        set_req(0, ADD, 32'd1, 32'd2);
        set_req(1, ADD, 32'd3, 32'd4);
        #1;
        check("rr favours req0", 32'(req_ready), 32'b01);
        nacc = 0;
        cyc  = 0;
        while (nacc < 6 && cyc < 40) begin
            if (req_ready != '0) begin
                grants[nacc] = int'(req_ready[1]);
                times[nacc]  = cyc;
                nacc++;
            end
            step();
            cyc++;
        end
        check("cont accepts", 32'(nacc), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("cont grant%0d", i), 32'(grants[i]), 32'(i % 2));
            if (i > 0)
                check($sformatf("cont gap%0d", i), 32'(times[i] - times[i-1]), 32'd3);
        end
        req_valid = '0;
        step();
        step();
        step();
        rsp_ready = '0;
        check("cont idle", 32'(busy), 32'd0);

        // Backpressure on req1; req0 waits; rsp_ready[0] ignored
        do_reset();
        set_req(1, LSL, 32'd1, 32'd2);
        #1;
        check("bp ready1", 32'(req_ready), 32'b10);
        step();
        req_valid[1] = 1'b0;
        set_req(0, ADD, 32'd5, 32'd6);
        #1;
        check("bp exec no ready", 32'(req_ready), 32'd0);
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp hold valid%0d", i), 32'(rsp_valid), 32'b10);
            check($sformatf("bp hold result%0d", i), rsp_result, 32'd4);
            check($sformatf("bp hold ready%0d", i), 32'(req_ready), 32'd0);
        end
        rsp_ready = 2'b10;
        step();
        rsp_ready = '0;
        #1;
        check("bp after hs busy", 32'(busy), 32'd0);
        check("bp after hs ready0", 32'(req_ready), 32'b01);
        step();
        req_valid[0] = 1'b0;
        step();
        check("bp req0 valid", 32'(rsp_valid), 32'b01);
        check("bp req0 result", rsp_result, 32'd11);
        rsp_ready[0] = 1'b1;
        step();
        rsp_ready = '0;

        // Operand change after accept
        set_req(0, OR_, 32'hC, 32'hA);
        #1;
        check("opchg ready", 32'(req_ready), 32'b01);
        step();
        req_valid[0] = 1'b0;
        req_a[0 +: RS] = 32'd0;
        req_sel[0 +: SL] = AND_;
        step();
        check("opchg valid", 32'(rsp_valid), 32'b01);
        check("opchg result", rsp_result, 32'hE);
        rsp_ready[0] = 1'b1;
        step();
        rsp_ready = '0;

        // Reset during EXEC: rr_ptr was 1, reset must return it to 0
        set_req(1, LSR, 32'h4, 32'd2);
        #1;
        check("rstx ready1", 32'(req_ready), 32'b10);
        step();
        req_valid[1] = 1'b0;
        rst = 1'b1;
        #1;
        check("rstx busy", 32'(busy), 32'd0);
        check("rstx rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstx grant", 32'(grant_id), 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        check("rstx no rsp", 32'(rsp_valid), 32'd0);
        check("rstx idle", 32'(busy), 32'd0);
        set_req(0, LSR, 32'h4, 32'd2);
        set_req(1, ADD, 32'd1, 32'd1);
        #1;
        check("rstx rr_ptr0", 32'(req_ready), 32'b01);
        step();
        req_valid = '0;
        step();
        check("rstx next valid", 32'(rsp_valid), 32'b01);
        check("rstx next result", rsp_result, 32'd1);
        rsp_ready[0] = 1'b1;
        step();
        rsp_ready = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
